fetch_stage_pq: RTL

//  Parametrised instruction-fetch stage with a prefetch queue. Decouples the

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_stage_pq_queue.sv | 66 ++++++
 rtl/fetch_stage_pq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: PC-select codes, the
// default fetch entry layout and the bubble encoding.
package fetch_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_BRANCH = 2'd2;
  localparam logic [1:0] PCSRC_RETURN = 2'd3;

  localparam int FETCH_DATA_W = 16;
  localparam int FETCH_ADDR_W = 16;

  localparam logic [FETCH_DATA_W-1:0] FETCH_NOP = 16'h0000;

  // Default-geometry view of one prefetch queue entry.
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_pq_queue.sv
// Synchronous FIFO for prefetched {instr, npc} entries with flush; pointers
// are log2(DEPTH) bits wide and wrap naturally.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] slot_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = slot_mem[rd_ptr_q];

  always_comb begin
    do_push  = push & (~full | pop) & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slot_mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_stage_pq.sv
// Instruction-fetch stage: issues 1-cycle-latency memory reads under a credit
// limit, buffers returns in a prefetch queue and feeds the IF/ID register.
module fetch_stage_pq
  import fetch_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                PC_STEP   = 1,
  parameter int                QDEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(FETCH_NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              kill,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] j_target,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_npc
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              epoch_q, epoch_d;
  logic              inflight_q, inflight_d;
  logic              infl_tag_q, infl_tag_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_npc_q, if_npc_d;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W:0]    credit;
  logic              req;

  logic              q_push, q_pop, q_full, q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_wdata, q_rdata;

  fetch_queue #(
    .WIDTH(ENT_W),
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (q_push),
    .pop  (q_pop),
    .flush(redirect),
    .wdata(q_wdata),
    .rdata(q_rdata),
    .full (q_full),
    .empty(q_empty),
    .count(q_count)
  );

  // Request issue, redirect mux and return acceptance.
  always_comb begin
    redirect    = (pc_src != PCSRC_SEQ);
    redirect_pc = fetch_pc_q;
    case (pc_src)
      PCSRC_JUMP:   redirect_pc = j_target;
      PCSRC_BRANCH: redirect_pc = i_target;
      PCSRC_RETURN: redirect_pc = ret_addr;
      default:      redirect_pc = fetch_pc_q;
    endcase

    // Queued plus in-flight entries never exceed QDEPTH, so a return always fits.
    credit = {1'b0, q_count} + (CNT_W+1)'(inflight_q);
    req    = rst_n & ~redirect & (credit < (CNT_W+1)'(QDEPTH));

    q_push  = imem_rvalid & inflight_q & (infl_tag_q == epoch_q) & ~redirect;
    q_wdata = {imem_rdata, infl_addr_q + ADDR_W'(PC_STEP)};

    fetch_pc_d  = fetch_pc_q;
    if (redirect)  fetch_pc_d = redirect_pc;
    else if (req)  fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    epoch_d     = epoch_q ^ redirect;
    inflight_d  = req;
    infl_tag_d  = epoch_q;
    infl_addr_d = fetch_pc_q;
  end

  // Output register: redirect beats stall, stall beats kill.
  always_comb begin
    q_pop      = 1'b0;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_npc_d   = if_npc_q;
    if (redirect) begin
      if_valid_d = 1'b0;
    end else if (!stall) begin
      if (kill) begin
        q_pop      = ~q_empty;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b1;
      end else if (!q_empty) begin
        q_pop      = 1'b1;
        if_instr_d = q_rdata[ENT_W-1:ADDR_W];
        if_npc_d   = q_rdata[ADDR_W-1:0];
        if_valid_d = 1'b1;
      end else begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
      inflight_q <= 1'b0;
      infl_tag_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_npc_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      inflight_q <= inflight_d;
      infl_tag_q <= infl_tag_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_npc_q   <= if_npc_d;
    end
  end

  always_ff @(posedge clk) begin
    infl_addr_q <= infl_addr_d;
  end

  assign imem_req  = req;
  assign imem_addr = fetch_pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_npc    = if_npc_q;

endmodule
